lfm_responder: RTL

- Memory-side end of the LFM (load-from-memory) page-table-walk interface.
- Accepts PTE fetch requests from the MMU walker (lfm_enable, lfm_addr) and issues a single-word read on the shared data-memory port.
- Returns the word with a one-cycle lfm_resolved pulse.
- Sits between MMU_unit and the data-memory arbiter. Tolerates the walker's level-held enable, which can stay high after the L0 fetch resolves.

---
 rtl/lfm_responder_if.sv | 36 +++
 rtl/lfm_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/lfm_responder_if.sv
// lfm_responder_if
//   Bundles the walker-side LFM request/response signals and the
//   data-memory arbiter read port seen by lfm_responder.
//
//   Walker side : lfm_enable, lfm_addr, mmu_busy (to responder)
//                 lfm_resolved, lfm_word, lfm_misaligned (from responder)
//   Memory side : mem_req, mem_addr (from responder)
//                 mem_gnt, mem_rvalid, mem_rdata (to responder)
//
//   Modports: slave  - the responder itself
//             master - the surrounding walker/arbiter environment
interface lfm_responder_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              lfm_enable;
    logic [ADDR_W-1:0] lfm_addr;
    logic              mmu_busy;
    logic              lfm_resolved;
    logic [31:0]       lfm_word;
    logic              lfm_misaligned;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport slave (
        input  lfm_enable, lfm_addr, mmu_busy, mem_gnt, mem_rvalid, mem_rdata,
        output lfm_resolved, lfm_word, lfm_misaligned, mem_req, mem_addr
    );

    modport master (
        output lfm_enable, lfm_addr, mmu_busy, mem_gnt, mem_rvalid, mem_rdata,
        input  lfm_resolved, lfm_word, lfm_misaligned, mem_req, mem_addr
    );
endinterface

// File: rtl/lfm_responder.sv
// lfm_responder
//   Memory-side end of the LFM page-table-walk interface. Accepts a PTE
//   fetch from the MMU walker, issues one word read to the data-memory
//   arbiter and returns the word with a one-cycle lfm_resolved pulse.
//   The walker's level-held lfm_enable is only served once per arm event
//   (lfm_enable seen low, or a rising edge on mmu_busy).
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     bus  - lfm_responder_if.slave (walker request/response + memory port)
//
//   Parameters:
//     ADDR_W         - width of lfm_addr / mem_addr
//     TIMEOUT_CYCLES - wait bound, used only with LFM_TIMEOUT_EN
//
//   Build option:
//     LFM_TIMEOUT_EN - when defined, a fetch that has not completed after
//                      TIMEOUT_CYCLES cycles in REQ/WAIT resolves with
//                      lfm_word = 0 (invalid PTE, walker page-faults).
module lfm_responder #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk,
    input  logic            rst,
    lfm_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    logic   armed;
    logic   mmu_busy_q;
    logic   arm_evt;

    // Elaboration-time sanity check on the wait bound.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef LFM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tcnt;
    logic          timed_out;

    always_comb begin
        timed_out = (tcnt == TW'(TIMEOUT_CYCLES - 1));
    end
`endif

    always_comb begin
        arm_evt = !bus.lfm_enable || (bus.mmu_busy && !mmu_busy_q);
    end

    // Arm events take priority over the clears below, so an arm event in
    // the RESP cycle (or the cycle entering RESP) leaves armed set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            armed              <= 1'b1;
            mmu_busy_q         <= 1'b0;
            bus.lfm_resolved   <= 1'b0;
            bus.lfm_word       <= '0;
            bus.lfm_misaligned <= 1'b0;
            bus.mem_req        <= 1'b0;
            bus.mem_addr       <= '0;
`ifdef LFM_TIMEOUT_EN
            tcnt               <= '0;
`endif
        end else begin
            mmu_busy_q       <= bus.mmu_busy;
            bus.lfm_resolved <= 1'b0;
            if (arm_evt) begin
                armed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.lfm_enable && armed) begin
                        state              <= REQ;
                        bus.mem_req        <= 1'b1;
                        bus.mem_addr       <= {bus.lfm_addr[ADDR_W-1:2], 2'b00};
                        bus.lfm_misaligned <= |bus.lfm_addr[1:0];
`ifdef LFM_TIMEOUT_EN
                        tcnt               <= '0;
`endif
                    end
                end

                REQ: begin
                    if (bus.mem_gnt && bus.mem_rvalid) begin
                        bus.mem_req      <= 1'b0;
                        bus.lfm_word     <= bus.mem_rdata;
                        bus.lfm_resolved <= 1'b1;
                        state            <= RESP;
                        if (!arm_evt) armed <= 1'b0;
`ifdef LFM_TIMEOUT_EN
                    end else if (timed_out) begin
                        bus.mem_req      <= 1'b0;
                        bus.lfm_word     <= '0;
                        bus.lfm_resolved <= 1'b1;
                        state            <= RESP;
                        if (!arm_evt) armed <= 1'b0;
`endif
                    end else if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= WAIT;
                    end
`ifdef LFM_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
`endif
                end

                WAIT: begin
                    if (bus.mem_rvalid) begin
                        bus.lfm_word     <= bus.mem_rdata;
                        bus.lfm_resolved <= 1'b1;
                        state            <= RESP;
                        if (!arm_evt) armed <= 1'b0;
`ifdef LFM_TIMEOUT_EN
                    end else if (timed_out) begin
                        bus.lfm_word     <= '0;
                        bus.lfm_resolved <= 1'b1;
                        state            <= RESP;
                        if (!arm_evt) armed <= 1'b0;
`endif
                    end
`ifdef LFM_TIMEOUT_EN
                    tcnt <= tcnt + 1'b1;
`endif
                end

                RESP: begin
                    state <= IDLE;
                    if (!arm_evt) armed <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
